// File: rtl/rotate_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rotate_scheduler_pkg
// Brief    : Shared types and width/pointer helpers for rotate_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package rotate_scheduler_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    function automatic int amt_width(input int dw);
        return (dw < 2) ? 1 : $clog2(dw);
    endfunction

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int next_ptr(input int k, input int n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rotate_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : rotate_scheduler_if
// Brief    : Requester and consumer handshake bundle for rotate_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface rotate_scheduler_if
    import rotate_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
) ();
    localparam int AMT_WIDTH = amt_width(DATA_WIDTH);
    localparam int ID_WIDTH  = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]                 i_valid;
    logic [NUM_REQ-1:0]                 o_ready;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] i_data;
    logic [NUM_REQ-1:0][AMT_WIDTH-1:0]  i_amt;
    logic                               o_valid;
    logic                               i_ready;
    logic [DATA_WIDTH-1:0]              o_data;
    logic [ID_WIDTH-1:0]                o_id;

    modport slave (
        input  i_valid, i_data, i_amt, i_ready,
        output o_ready, o_valid, o_data, o_id
    );

    modport master (
        output i_valid, i_data, i_amt, i_ready,
        input  o_ready, o_valid, o_data, o_id
    );
endinterface
`default_nettype wire

// File: rtl/rotate.sv
`default_nettype none
// ============================================================================
// Module   : rotate
// Brief    : Combinational left rotate; amounts wrap modulo DATA_WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module rotate
    import rotate_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]            data_i,
    input  logic [amt_width(DATA_WIDTH)-1:0] amt_i,
    output logic [DATA_WIDTH-1:0]            data_o
);
    int w_sh;

    // A zero shift makes the right-shift term DATA_WIDTH wide, which yields 0.
    assign w_sh   = int'(amt_i) % DATA_WIDTH;
    assign data_o = (data_i << w_sh) | (data_i >> (DATA_WIDTH - w_sh));
endmodule
`default_nettype wire

// File: rtl/rotate_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter, search starts at ptr_i.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import rotate_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [id_width(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]           grant_o
);
    localparam int ID_WIDTH = id_width(NUM_REQ);

    logic w_found;
    int   w_idx;

    always_comb begin
        grant_o = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = (int'(ptr_i) + i) % NUM_REQ;
            if (!w_found && req_i[w_idx[ID_WIDTH-1:0]]) begin
                grant_o[w_idx[ID_WIDTH-1:0]] = 1'b1;
                w_found                      = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/rotate_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rotate_scheduler
// Brief    : Round-robin sharing of one rotate datapath with a registered
//            one-entry output stage tagged with the requester index.
// Revision : 1.0 - initial release
// ============================================================================
module rotate_scheduler
    import rotate_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic              clk,
    input  logic              areset,
    rotate_scheduler_if.slave bus
);
    localparam int AMT_WIDTH = amt_width(DATA_WIDTH);
    localparam int ID_WIDTH  = id_width(NUM_REQ);

    out_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;

    logic [NUM_REQ-1:0]    w_grant;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_load_en;
    logic                  w_xfer;
    logic [ID_WIDTH-1:0]   w_gnt_id;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [AMT_WIDTH-1:0]  w_sel_amt;
    logic [DATA_WIDTH-1:0] w_rot;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (bus.i_valid),
        .ptr_i   (ptr_q),
        .grant_o (w_grant)
    );

    // Ready is gated by reset so no requester sees an accept while in reset.
    assign w_load_en = (state_q == EMPTY) || bus.i_ready;
    assign w_ready   = w_grant & {NUM_REQ{w_load_en && !areset}};
    assign w_xfer    = |w_ready;

    always_comb begin
        w_gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) w_gnt_id = ID_WIDTH'(i);
        end
        w_sel_data = bus.i_data[w_gnt_id];
        w_sel_amt  = bus.i_amt[w_gnt_id];
    end

    rotate #(.DATA_WIDTH(DATA_WIDTH)) u_rot (
        .data_i (w_sel_data),
        .amt_i  (w_sel_amt),
        .data_o (w_rot)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            EMPTY:   if (w_xfer) state_d = FULL;
            FULL:    if (bus.i_ready && !w_xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (w_xfer) begin
            data_d = w_rot;
            id_d   = w_gnt_id;
            ptr_d  = ID_WIDTH'(next_ptr(int'(w_gnt_id), NUM_REQ));
        end
    end

    assign bus.o_ready = w_ready;
    assign bus.o_valid = (state_q == FULL);
    assign bus.o_data  = data_q;
    assign bus.o_id    = id_q;
endmodule
`default_nettype wire

// File: doc/rotate_scheduler.md
# rotate_scheduler

Shares a single `rotate` datapath between `NUM_REQ` independent requesters through a round-robin arbiter. Each requester submits a word and a rotate amount over a valid/ready handshake. The block selects one request per cycle, rotates the word left by the amount, and holds the result in a one-entry registered output stage. The output carries the requester index. It sits between several bit-manipulation clients and a single downstream consumer.

## Interface

**Parameters**
- `DATA_WIDTH`, default 8: word width in bits; must be ≥ 2.
- `NUM_REQ`, default 4: number of requesters; must be ≥ 2.
- Derived widths (not overridable):
  - `AMT_WIDTH = $clog2(DATA_WIDTH)`
  - `ID_WIDTH = $clog2(NUM_REQ)`

**Ports**
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `areset`  in  1: reset, asynchronous and active-high.
- `i_valid`  in  `[NUM_REQ-1:0]`: per-requester request valid.
- `o_ready`  out  `[NUM_REQ-1:0]`: per-requester accept, one-hot or zero.
- `i_data`  in  `[NUM_REQ-1:0][DATA_WIDTH-1:0]`: per-requester word.
- `i_amt`  in  `[NUM_REQ-1:0][AMT_WIDTH-1:0]`: per-requester left-rotate amount.
- `o_valid`  out  1: result register holds a valid result.
- `i_ready`  in  1: downstream accepts the result.
- `o_data`  out  `[DATA_WIDTH-1:0]`: rotated word.
- `o_id`  out  `[ID_WIDTH-1:0]`: index of the requester that produced `o_data`.

## Operation

**Output stage state machine**
- Two states, encoded by `o_valid`:
  - `EMPTY` (`o_valid`=0)
  - `FULL` (`o_valid`=1)
- Define `load_en = !o_valid || i_ready`.

**Arbitration**
- Round-robin pointer `rr_ptr` (`ID_WIDTH` bits).
- The grant goes to the first `k` with `i_valid[k]=1`, searching `rr_ptr`, `rr_ptr+1`, … and wrapping modulo `NUM_REQ`.
- `o_ready[k] = grant[k] && load_en`. This is combinational from `i_valid`, `o_valid` and `i_ready`.
- `o_ready` never depends on `i_data` or `i_amt`.

**Transfer**
- A transfer occurs when `i_valid[k] && o_ready[k]`. On that edge:
  - `o_data` loads the left rotation of `i_data[k]`: bit `(i+amt) mod DATA_WIDTH` of the result equals bit `i` of the input.
  - `o_id` loads `k`.
  - `o_valid` is set to 1.
  - `rr_ptr` loads `(k+1) mod NUM_REQ`.

**Amount rules**
- For non-power-of-two `DATA_WIDTH`, amounts ≥ `DATA_WIDTH` wrap modulo `DATA_WIDTH`.
- Amount 0 passes the word through unchanged.

**State transitions**
- `EMPTY`, no request: stay `EMPTY`.
- `EMPTY`, any `i_valid`: load the result and go `FULL`.
- `FULL`, `!i_ready`: hold `o_data`, `o_id` and `o_valid`; all `o_ready` are 0; `rr_ptr` holds.
- `FULL`, `i_ready`, a request present: load the new result and stay `FULL`. This is back-to-back operation at 1 result per cycle.
- `FULL`, `i_ready`, no request: clear `o_valid` and go `EMPTY`. `o_data` and `o_id` keep their stale values.

**Requester obligations**
- Once `i_valid[k]` is asserted, it must stay high with stable `i_data[k]` and `i_amt[k]` until accepted.
- The block does not check this obligation.

**Boundary conditions**
- All requesters valid: grants rotate k, k+1, … with no requester served twice before every other valid requester is served once.
- A single requester valid continuously: it is granted every cycle that `load_en` is high.
- Pointer wrap: after a grant to `NUM_REQ-1`, `rr_ptr` becomes 0.

**Reset**
- Asserting `areset` forces, immediately and asynchronously:
  - `o_valid`=0
  - `o_data`=0
  - `o_id`=0
  - `rr_ptr`=0
- While `areset` is high, `o_ready`=0. An in-flight result is discarded.
- Operation resumes on the first rising edge after deassertion.

## Timing

- Latency is 1 cycle from an accepted request to `o_valid` with its result.
- Throughput is 1 result per cycle while `i_ready` stays high.
- The only combinational paths are:
  - `i_valid`, `o_valid`, `i_ready` → `o_ready`
  - `i_data`, `i_amt` → rotate → `o_data` D-input
- No combinational path from `i_valid` or `i_data` to `o_valid`, `o_data` or `o_id`.

## Structure

- Package `rotate_scheduler_pkg` holds:
  - the `AMT_WIDTH` and `ID_WIDTH` derivation functions;
  - the next-pointer function that takes `(k+1) mod NUM_REQ`.
- Sub-modules:
  - One instance of the existing `rotate` module, with `DATA_WIDTH` passed through, fed by the granted requester's mux output.
  - The round-robin arbiter is a natural sub-module, `rr_arbiter`: parameter `NUM_REQ`, inputs request vector and pointer, output one-hot grant. It is purely combinational; `rr_ptr` lives in `rotate_scheduler`.

## Test plan

- **Reset and idle.** Assert `areset` mid-transfer with `o_valid`=1 → `o_valid`, `o_data`, `o_id` = 0 and `o_ready`=0 immediately; no output after release until a new request.
- **Single rotate.** Use `DATA_WIDTH`=8 and requester 2 with `i_data`=0x81, `i_amt`=1 → next cycle `o_valid`=1, `o_data`=0x03, `o_id`=2. With `i_amt`=0 and 0xA5 → `o_data`=0xA5.
- **Fairness.** Hold all 4 requesters valid with `i_ready`=1 → accepted ids are 0,1,2,3,0,1…, one per cycle, with `o_ready` one-hot each cycle.
- **Backpressure.** Hold `i_ready`=0 for 3 cycles while `FULL` → `o_data`/`o_id` stable, `o_ready`=0, `rr_ptr` unchanged. On `i_ready`=1, the next grant follows the pointer.
- **Skip and wrap.** Valid only on requesters 1 and 3, starting from `rr_ptr`=0 → grant sequence 1,3,1,3.
- **Non-power-of-two width.** Use `DATA_WIDTH`=6 with `i_data`=6'b000001, `i_amt`=7 → `o_data`=6'b000010. Random data and amounts are checked against a software model.
